// File: rtl/ready_pkg.sv
// Shared types for the XT bus-ready / wait-state generator.
// State encoding and bus-cycle class used by ready_wait_gen.
package ready_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        EXTEND = 2'd2,
        DONE   = 2'd3
    } ready_state_t;

    typedef enum logic {
        CYC_IO  = 1'b0,
        CYC_MEM = 1'b1
    } cyc_type_t;

    // Ready is presented to the bus whenever the machine is (or is about to be)
    // outside the wait/extend region.
    function automatic logic is_ready_state(input ready_state_t s);
        return (s == IDLE) || (s == DONE);
    endfunction

endpackage

// File: rtl/ready_down_counter.sv
// Loadable down counter with saturation at zero.
// Load has priority over decrement; the value never wraps below zero.
module ready_down_counter #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         is_one,
    output logic         is_zero
);

    // Count register: load wins, decrement stops at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (dec && (value != '0)) begin
            value <= value - W'(1);
        end else begin
            value <= value;
        end
    end

    assign is_one  = (value == W'(1));
    assign is_zero = (value == '0);

endmodule

// File: rtl/ready_wait_gen.sv
// Bus-ready / wait-state generator for the XT chipset (8284 READY replacement).
// Inserts a programmable number of wait clocks per bus-cycle class (I/O or
// memory), stretches any cycle while io_channel_ready is low, and drives
// dma_ready (posedge) and processor_ready (negedge) ready lines.
// Optional feature macro: READY_TIMEOUT_EN bounds the channel-ready extension
// to TIMEOUT_CYCLES clocks and flags a forced completion on timeout_pulse.
module ready_wait_gen
    import ready_pkg::*;
#(
    parameter int WAIT_W         = 4,
    parameter int TIMEOUT_W      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WAIT_W-1:0] io_wait_cfg,
    input  logic [WAIT_W-1:0] mem_wait_cfg,
    input  logic              io_read_n,
    input  logic              io_write_n,
    input  logic              memory_read_n,
    input  logic              memory_write_n,
    input  logic              dma0_acknowledge_n,
    input  logic              address_enable_n,
    input  logic              io_channel_ready,
    input  logic              dma_wait_n,
    output logic              dma_ready,
    output logic              processor_ready,
    output logic              busy,
    output logic              timeout_pulse
);

    logic              io_cyc;
    logic              mem_cyc;
    logic              bus_state;
    logic              prev_bus_state;
    logic              start;
    cyc_type_t         cyc_type;
    logic [WAIT_W-1:0] start_cfg;

    ready_state_t      state;
    ready_state_t      next_state;
    logic              ready_int;

    logic              wait_load;
    logic [WAIT_W-1:0] wait_load_value;
    logic              wait_dec;
    logic [WAIT_W-1:0] wait_value;
    logic              wait_is_one;
    logic              wait_is_zero;
    logic              wait_expired;

    logic              timeout_fire;

    // Refresh (DMA ch0) and DMA-owned memory cycles never get wait states.
    assign io_cyc    = ~io_read_n | ~io_write_n;
    assign mem_cyc   = (~memory_read_n | ~memory_write_n) & dma0_acknowledge_n & address_enable_n;
    assign bus_state = io_cyc | mem_cyc;
    assign start     = bus_state & ~prev_bus_state;

    // I/O has priority when both classes are decoded at once.
    assign cyc_type  = io_cyc ? CYC_IO : CYC_MEM;
    assign start_cfg = (cyc_type == CYC_IO) ? io_wait_cfg : mem_wait_cfg;

    // A zero count in WAIT cannot normally happen; treat it as expired so the
    // machine can never stall there.
    assign wait_expired = wait_is_one | wait_is_zero;

    assign ready_int = is_ready_state(next_state);
    assign busy      = (state != IDLE);

    // Next-state decode; a falling bus_state always returns to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (start_cfg != '0) begin
                        next_state = WAIT;
                    end else if (io_channel_ready) begin
                        next_state = DONE;
                    end else begin
                        next_state = EXTEND;
                    end
                end else begin
                    next_state = IDLE;
                end
            end
            WAIT: begin
                if (!bus_state) begin
                    next_state = IDLE;
                end else if (wait_expired) begin
                    next_state = io_channel_ready ? DONE : EXTEND;
                end else begin
                    next_state = WAIT;
                end
            end
            EXTEND: begin
                if (!bus_state) begin
                    next_state = IDLE;
                end else if (io_channel_ready || timeout_fire) begin
                    next_state = DONE;
                end else begin
                    next_state = EXTEND;
                end
            end
            DONE: begin
                if (!bus_state) begin
                    next_state = IDLE;
                end else begin
                    next_state = DONE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Wait counter control: load at cycle start, clear when returning to IDLE,
    // otherwise count down while staying in WAIT.
    always_comb begin
        wait_load       = 1'b0;
        wait_load_value = '0;
        wait_dec        = 1'b0;
        if ((state == IDLE) && start) begin
            wait_load       = 1'b1;
            wait_load_value = start_cfg;
        end else if ((state != IDLE) && (next_state == IDLE)) begin
            wait_load       = 1'b1;
            wait_load_value = '0;
        end else if ((state == WAIT) && (next_state == WAIT)) begin
            wait_dec = 1'b1;
        end else begin
            wait_dec = 1'b0;
        end
    end

    ready_down_counter #(
        .W (WAIT_W)
    ) u_wait_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (wait_load),
        .load_value (wait_load_value),
        .dec        (wait_dec),
        .value      (wait_value),
        .is_one     (wait_is_one),
        .is_zero    (wait_is_zero)
    );

`ifdef READY_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TMO_LOAD = TIMEOUT_W'(TIMEOUT_CYCLES);

    logic                 tmo_load;
    logic [TIMEOUT_W-1:0] tmo_load_value;
    logic                 tmo_dec;
    logic [TIMEOUT_W-1:0] tmo_value;
    logic                 tmo_is_one;
    logic                 tmo_is_zero;

    // Forced completion on the last allowed EXTEND clock with the channel still low.
    assign timeout_fire = (state == EXTEND) & bus_state & ~io_channel_ready
                        & (tmo_is_one | tmo_is_zero);

    // Timeout counter control: re-armed on entry to EXTEND, cleared on exit.
    always_comb begin
        tmo_load       = 1'b0;
        tmo_load_value = '0;
        tmo_dec        = 1'b0;
        if ((state != EXTEND) && (next_state == EXTEND)) begin
            tmo_load       = 1'b1;
            tmo_load_value = TMO_LOAD;
        end else if ((state == EXTEND) && (next_state != EXTEND)) begin
            tmo_load       = 1'b1;
            tmo_load_value = '0;
        end else if (state == EXTEND) begin
            tmo_dec = 1'b1;
        end else begin
            tmo_dec = 1'b0;
        end
    end

    ready_down_counter #(
        .W (TIMEOUT_W)
    ) u_timeout_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (tmo_load),
        .load_value (tmo_load_value),
        .dec        (tmo_dec),
        .value      (tmo_value),
        .is_one     (tmo_is_one),
        .is_zero    (tmo_is_zero)
    );
`else
    // Extension is unbounded in this build.
    assign timeout_fire = 1'b0;
`endif

    // Posedge state: FSM, bus-state history, dma_ready and the timeout flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            prev_bus_state <= 1'b1;
            dma_ready      <= 1'b0;
            timeout_pulse  <= 1'b0;
        end else begin
            state          <= next_state;
            prev_bus_state <= bus_state;
            dma_ready      <= ready_int;
            timeout_pulse  <= timeout_fire;
        end
    end

    // CPU ready is re-timed on the falling edge and gated by the arbiter.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            processor_ready <= 1'b0;
        end else begin
            processor_ready <= dma_wait_n & dma_ready;
        end
    end

endmodule

// File: tb/tb_ready_wait_gen.sv
// Directed self-checking bench for ready_wait_gen.
// Build with READY_TIMEOUT_EN defined to exercise the bounded extension.
module tb_ready_wait_gen;

`ifdef READY_TIMEOUT_EN
    localparam int TB_TMO = 4;
`else
    localparam int TB_TMO = 255;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] io_wait_cfg = 4'd0;
    logic [3:0] mem_wait_cfg = 4'd0;
    logic       io_read_n = 1'b1;
    logic       io_write_n = 1'b1;
    logic       memory_read_n = 1'b1;
    logic       memory_write_n = 1'b1;
    logic       dma0_acknowledge_n = 1'b1;
    logic       address_enable_n = 1'b1;
    logic       io_channel_ready = 1'b1;
    logic       dma_wait_n = 1'b1;
    logic       dma_ready;
    logic       processor_ready;
    logic       busy;
    logic       timeout_pulse;

    int errors = 0;
    int checks = 0;

    ready_wait_gen #(
        .WAIT_W         (4),
        .TIMEOUT_W      (8),
        .TIMEOUT_CYCLES (TB_TMO)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .io_wait_cfg        (io_wait_cfg),
        .mem_wait_cfg       (mem_wait_cfg),
        .io_read_n          (io_read_n),
        .io_write_n         (io_write_n),
        .memory_read_n      (memory_read_n),
        .memory_write_n     (memory_write_n),
        .dma0_acknowledge_n (dma0_acknowledge_n),
        .address_enable_n   (address_enable_n),
        .io_channel_ready   (io_channel_ready),
        .dma_wait_n         (dma_wait_n),
        .dma_ready          (dma_ready),
        .processor_ready    (processor_ready),
        .busy               (busy),
        .timeout_pulse      (timeout_pulse)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_idle();
        io_read_n          = 1'b1;
        io_write_n         = 1'b1;
        memory_read_n      = 1'b1;
        memory_write_n     = 1'b1;
        dma0_acknowledge_n = 1'b1;
        address_enable_n   = 1'b1;
        io_channel_ready   = 1'b1;
        dma_wait_n         = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        #2;
        checks++; if (dma_ready !== 1'b0) begin errors++; $display("FAIL reset_dma_ready got %b want 0", dma_ready); end
        checks++; if (processor_ready !== 1'b0) begin errors++; $display("FAIL reset_processor_ready got %b want 0", processor_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL reset_timeout_pulse got %b want 0", timeout_pulse); end
        @(negedge clock);
        reset = 1'b0;
        step();
        checks++; if (dma_ready !== 1'b1) begin errors++; $display("FAIL post_reset_dma_ready got %b want 1", dma_ready); end
        checks++; if (processor_ready !== 1'b0) begin errors++; $display("FAIL post_reset_proc_before_negedge got %b want 0", processor_ready); end
        @(negedge clock);
        #1;
        checks++; if (processor_ready !== 1'b1) begin errors++; $display("FAIL post_reset_proc_after_negedge got %b want 1", processor_ready); end
    endtask

    task automatic test_io_wait3();
        logic exp;
        io_wait_cfg = 4'd3;
        io_read_n   = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            exp = (i <= 3) ? 1'b0 : 1'b1;
            checks++; if (dma_ready !== exp) begin errors++; $display("FAIL io_wait3_dma_ready step %0d got %b want %b", i, dma_ready, exp); end
            if (i == 1) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL io_wait3_busy got %b want 1", busy); end
            end
            if (i == 4) begin
                checks++; if (processor_ready !== 1'b0) begin errors++; $display("FAIL io_wait3_proc_early got %b want 0", processor_ready); end
                @(negedge clock);
                #1;
                checks++; if (processor_ready !== 1'b1) begin errors++; $display("FAIL io_wait3_proc_follow got %b want 1", processor_ready); end
            end
        end
        io_read_n = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL io_wait3_end_busy got %b want 0", busy); end
        bus_idle();
    endtask

    task automatic test_mem_zero();
        mem_wait_cfg  = 4'd0;
        io_wait_cfg   = 4'd7;
        memory_read_n = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++; if (dma_ready !== 1'b1) begin errors++; $display("FAIL mem_zero_dma_ready step %0d got %b want 1", i, dma_ready); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mem_zero_busy step %0d got %b want 1", i, busy); end
        end
        memory_read_n = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mem_zero_end_busy got %b want 0", busy); end
        bus_idle();
    endtask

    task automatic test_priority();
        int lows;
        io_wait_cfg    = 4'd2;
        mem_wait_cfg   = 4'd6;
        io_read_n      = 1'b0;
        memory_write_n = 1'b0;
        lows = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (dma_ready === 1'b0) lows++;
        end
        checks++; if (lows != 2) begin errors++; $display("FAIL priority_low_clocks got %0d want 2", lows); end
        io_read_n = 1'b1;
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL priority_mem_still_busy got %b want 1", busy); end
        memory_write_n = 1'b1;
        bus_idle();
        mem_wait_cfg  = 4'd4;
        memory_read_n = 1'b0;
        lows = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (dma_ready === 1'b0) lows++;
        end
        checks++; if (lows != 4) begin errors++; $display("FAIL mem_cfg_low_clocks got %0d want 4", lows); end
        bus_idle();
    endtask

    task automatic test_dma_block();
        mem_wait_cfg       = 4'd3;
        memory_read_n      = 1'b0;
        dma0_acknowledge_n = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL refresh_busy step %0d got %b want 0", i, busy); end
            checks++; if (dma_ready !== 1'b1) begin errors++; $display("FAIL refresh_dma_ready step %0d got %b want 1", i, dma_ready); end
        end
        memory_read_n      = 1'b1;
        dma0_acknowledge_n = 1'b1;
        step();
        address_enable_n = 1'b0;
        memory_write_n   = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL aen_busy step %0d got %b want 0", i, busy); end
        end
        memory_write_n   = 1'b1;
        address_enable_n = 1'b1;
        bus_idle();
    endtask

    task automatic test_abort();
        logic exp;
        io_wait_cfg = 4'd5;
        io_write_n  = 1'b0;
        step();
        checks++; if (dma_ready !== 1'b0) begin errors++; $display("FAIL abort_dma_low got %b want 0", dma_ready); end
        step();
        io_write_n = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (dma_ready !== 1'b1) begin errors++; $display("FAIL abort_dma_ready got %b want 1", dma_ready); end
        io_write_n = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            exp = (i <= 5) ? 1'b0 : 1'b1;
            checks++; if (dma_ready !== exp) begin errors++; $display("FAIL restart_dma_ready step %0d got %b want %b", i, dma_ready, exp); end
        end
        bus_idle();
    endtask

    task automatic test_dma_wait();
        dma_wait_n = 1'b0;
        @(negedge clock);
        #1;
        checks++; if (processor_ready !== 1'b0) begin errors++; $display("FAIL dma_wait_block got %b want 0", processor_ready); end
        checks++; if (dma_ready !== 1'b1) begin errors++; $display("FAIL dma_wait_dma_ready got %b want 1", dma_ready); end
        dma_wait_n = 1'b1;
        @(negedge clock);
        #1;
        checks++; if (processor_ready !== 1'b1) begin errors++; $display("FAIL dma_wait_release got %b want 1", processor_ready); end
        bus_idle();
    endtask

`ifndef READY_TIMEOUT_EN
    task automatic test_extend();
        io_wait_cfg      = 4'd1;
        io_read_n        = 1'b0;
        io_channel_ready = 1'b0;
        for (int i = 1; i <= 21; i++) begin
            step();
            checks++; if (dma_ready !== 1'b0) begin errors++; $display("FAIL extend_dma_low step %0d got %b want 0", i, dma_ready); end
            checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL extend_no_timeout step %0d got %b want 0", i, timeout_pulse); end
        end
        io_channel_ready = 1'b1;
        step();
        checks++; if (dma_ready !== 1'b1) begin errors++; $display("FAIL extend_dma_rise got %b want 1", dma_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL extend_done_busy got %b want 1", busy); end
        io_read_n = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL extend_end_busy got %b want 0", busy); end
        bus_idle();
    endtask
`else
    task automatic test_timeout();
        logic exp_dma;
        logic exp_tp;
        int   pulses;
        io_wait_cfg      = 4'd0;
        io_read_n        = 1'b0;
        io_channel_ready = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 7; i++) begin
            step();
            exp_dma = (i <= 4) ? 1'b0 : 1'b1;
            exp_tp  = (i == 5) ? 1'b1 : 1'b0;
            if (timeout_pulse === 1'b1) pulses++;
            checks++; if (dma_ready !== exp_dma) begin errors++; $display("FAIL timeout_dma_ready step %0d got %b want %b", i, dma_ready, exp_dma); end
            checks++; if (timeout_pulse !== exp_tp) begin errors++; $display("FAIL timeout_pulse step %0d got %b want %b", i, timeout_pulse, exp_tp); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy step %0d got %b want 1", i, busy); end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL timeout_pulse_count got %0d want 1", pulses); end
        io_read_n = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_end_busy got %b want 0", busy); end
        bus_idle();
    endtask
`endif

    task automatic test_reset_mid_wait();
        io_wait_cfg = 4'd5;
        io_read_n   = 1'b0;
        step();
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midwait_busy_before got %b want 1", busy); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (dma_ready !== 1'b0) begin errors++; $display("FAIL midwait_reset_dma_ready got %b want 0", dma_ready); end
        checks++; if (processor_ready !== 1'b0) begin errors++; $display("FAIL midwait_reset_proc got %b want 0", processor_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midwait_reset_busy got %b want 0", busy); end
        checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL midwait_reset_tp got %b want 0", timeout_pulse); end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++; if (dma_ready !== 1'b1) begin errors++; $display("FAIL no_start_dma_ready step %0d got %b want 1", i, dma_ready); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL no_start_busy step %0d got %b want 0", i, busy); end
        end
        bus_idle();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_io_wait3();
        test_mem_zero();
        test_priority();
        test_dma_block();
        test_abort();
        test_dma_wait();
`ifndef READY_TIMEOUT_EN
        test_extend();
`else
        test_timeout();
`endif
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
